// File: rtl/alu_seq_ctrl_if.sv
// Sequencer bus: instruction handshake, ALU drive/response and completion report.
// master = instruction source and ALU side, slave = alu_seq_ctrl.
interface alu_seq_ctrl_if #(
  parameter int unsigned DW   = 8,
  parameter int unsigned NREG = 4
);
  localparam int unsigned AW = $clog2(NREG);

  logic          instr_valid;
  logic          instr_ready;
  logic [3:0]    instr_op;
  logic [AW-1:0] instr_rd;
  logic [AW-1:0] instr_rs1;
  logic [AW-1:0] instr_rs2;
  logic          imm_sel;
  logic [DW-1:0] instr_imm;

  logic          alu_en;
  logic          alu_oe;
  logic [3:0]    alu_opcode;
  logic [DW-1:0] alu_a;
  logic [DW-1:0] alu_b;
  logic [DW-1:0] alu_out;
  logic          alu_cf;
  logic          alu_of;
  logic          alu_sf;
  logic          alu_zf;

  logic          done_valid;
  logic [AW-1:0] done_rd;
  logic [DW-1:0] done_data;

  modport master (
    output instr_valid, instr_op, instr_rd, instr_rs1, instr_rs2, imm_sel, instr_imm,
    output alu_out, alu_cf, alu_of, alu_sf, alu_zf,
    input  instr_ready, alu_en, alu_oe, alu_opcode, alu_a, alu_b,
    input  done_valid, done_rd, done_data
  );

  modport slave (
    input  instr_valid, instr_op, instr_rd, instr_rs1, instr_rs2, imm_sel, instr_imm,
    input  alu_out, alu_cf, alu_of, alu_sf, alu_zf,
    output instr_ready, alu_en, alu_oe, alu_opcode, alu_a, alu_b,
    output done_valid, done_rd, done_data
  );
endinterface

// File: rtl/alu_seq_ctrl.sv
// Serial instruction sequencer feeding an external ALU, with a small register file.
// Optional ALU_SEQ_PERF_EN adds retired-instruction and carry-out counters.
module alu_seq_ctrl #(
  parameter  int unsigned DW      = 8,
  parameter  int unsigned NREG    = 4,
  parameter  int unsigned ALU_LAT = 1,
  localparam int unsigned AW      = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst_n,
  alu_seq_ctrl_if.slave bus,
  output logic [3:0]    flags,
  output logic          busy,
  input  logic [AW-1:0] dbg_addr,
  output logic [DW-1:0] dbg_data
`ifdef ALU_SEQ_PERF_EN
  ,
  output logic [15:0]   perf_instr_cnt,
  output logic [15:0]   perf_cf_cnt
`endif
);

  localparam int unsigned CW       = 4;
  localparam logic [3:0]  OP_LOADI = 4'hF;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, WB} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    op_q;
  logic [3:0]    cap_flags_q;
  logic          ready_q;
  logic          accept;
  logic          capture;
  logic          alu_en_d, alu_oe_d, done_valid_d, busy_d, ready_d;
  logic [DW-1:0] rf_q [NREG];

  // Next state and decoded next values of the registered control outputs.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    accept       = 1'b0;
    capture      = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.instr_valid) begin
          accept  = 1'b1;
          state_d = (bus.instr_op == OP_LOADI) ? WB : ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = CW'(ALU_LAT);
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          capture = 1'b1;
          state_d = WB;
        end
      end
      WB:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
    alu_en_d     = (state_d == ISSUE);
    alu_oe_d     = (state_d == WAIT);
    done_valid_d = (state_d == WB);
    busy_d       = (state_d != IDLE);
    ready_d      = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      ready_q        <= 1'b1;
      busy           <= 1'b0;
      bus.alu_en     <= 1'b0;
      bus.alu_oe     <= 1'b0;
      bus.done_valid <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      ready_q        <= ready_d;
      busy           <= busy_d;
      bus.alu_en     <= alu_en_d;
      bus.alu_oe     <= alu_oe_d;
      bus.done_valid <= done_valid_d;
    end
  end

  // Ready is forced low while reset is held, high again as soon as it releases.
  assign bus.instr_ready = ready_q & rst_n;

  // Operands are read at acceptance so they are already on the ALU bus during ISSUE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q           <= '0;
      bus.alu_opcode <= '0;
      bus.alu_a      <= '0;
      bus.alu_b      <= '0;
    end else if (accept) begin
      op_q <= bus.instr_op;
      if (bus.instr_op != OP_LOADI) begin
        bus.alu_opcode <= bus.instr_op;
        bus.alu_a      <= rf_q[bus.instr_rs1];
        bus.alu_b      <= bus.imm_sel ? bus.instr_imm : rf_q[bus.instr_rs2];
      end
    end
  end

  // done_data doubles as the captured ALU result; flags commit only at the end of WB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.done_rd   <= '0;
      bus.done_data <= '0;
      cap_flags_q   <= '0;
      flags         <= '0;
    end else begin
      if (accept) begin
        bus.done_rd <= bus.instr_rd;
        if (bus.instr_op == OP_LOADI) bus.done_data <= bus.instr_imm;
      end
      if (capture) begin
        bus.done_data <= bus.alu_out;
        cap_flags_q   <= {bus.alu_cf, bus.alu_of, bus.alu_sf, bus.alu_zf};
      end
      if (state_q == WB && op_q != OP_LOADI) flags <= cap_flags_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NREG); i++) rf_q[i] <= '0;
    end else if (state_q == WB) begin
      rf_q[bus.done_rd] <= bus.done_data;
    end
  end

  assign dbg_data = rf_q[dbg_addr];

`ifdef ALU_SEQ_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_instr_cnt <= '0;
      perf_cf_cnt    <= '0;
    end else if (state_q == WB) begin
      perf_instr_cnt <= perf_instr_cnt + 16'd1;
      if (op_q != OP_LOADI && cap_flags_q[3]) perf_cf_cnt <= perf_cf_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Self-checking bench for alu_seq_ctrl: bench-side ALU model, register-file
// reference model, directed scenarios followed by random instruction streams.
module tb_alu_seq_ctrl;
  parameter int unsigned ALU_LAT = 1;
  localparam int unsigned DW   = 8;
  localparam int unsigned NREG = 4;
  localparam logic [3:0] OP_ADD   = 4'h2;
  localparam logic [3:0] OP_LOADI = 4'hF;

  typedef struct packed {
    logic [3:0] op;
    logic [1:0] rd;
    logic [1:0] rs1;
    logic [1:0] rs2;
    logic       sel;
    logic [7:0] imm;
  } instr_t;

  // mode 0: random idle gap before driving, 1: driven right after the previous
  // completes, 2: driven while the previous instruction is still busy
  typedef struct {
    instr_t ins;
    int     mode;
  } step_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] flags;
  logic       busy;
  logic [1:0] dbg_addr;
  logic [7:0] dbg_data;
`ifdef ALU_SEQ_PERF_EN
  logic [15:0] perf_instr_cnt;
  logic [15:0] perf_cf_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  logic [7:0]  rf_m [NREG];
  logic [3:0]  flags_m;
  int          perf_i_m;
  int          perf_cf_m;
  step_t       q[$];
  logic [11:0] alu_pipe [16];

  alu_seq_ctrl_if #(.DW(DW), .NREG(NREG)) bus ();

  alu_seq_ctrl #(.DW(DW), .NREG(NREG), .ALU_LAT(ALU_LAT)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .flags    (flags),
    .busy     (busy),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
`ifdef ALU_SEQ_PERF_EN
    ,
    .perf_instr_cnt (perf_instr_cnt),
    .perf_cf_cnt    (perf_cf_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Bench ALU: {cf,of,sf,zf,result}. 4'h2 is add; other opcodes get a distinct function.
  function automatic logic [11:0] alu_fn(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    logic [7:0] r;
    logic       cf;
    logic       of;
    if (op == OP_ADD) begin
      s  = {1'b0, a} + {1'b0, b};
      r  = s[7:0];
      cf = s[8];
      of = (a[7] == b[7]) && (r[7] != a[7]);
    end else begin
      r  = a ^ (b + {4'h0, op});
      cf = a[0] ^ b[7];
      of = 1'b0;
    end
    return {cf, of, r[7], (r == 8'h00), r};
  endfunction

  // Result appears ALU_LAT edges after the edge that samples alu_en; junk otherwise.
  always @(posedge clk) begin
    alu_pipe[0] <= bus.alu_en ? alu_fn(bus.alu_opcode, bus.alu_a, bus.alu_b) : 12'($urandom);
    for (int i = 1; i < 16; i++) alu_pipe[i] <= alu_pipe[i-1];
  end

  assign bus.alu_out = alu_pipe[4'(ALU_LAT - 1)][7:0];
  assign bus.alu_cf  = alu_pipe[4'(ALU_LAT - 1)][11];
  assign bus.alu_of  = alu_pipe[4'(ALU_LAT - 1)][10];
  assign bus.alu_sf  = alu_pipe[4'(ALU_LAT - 1)][9];
  assign bus.alu_zf  = alu_pipe[4'(ALU_LAT - 1)][8];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic instr_t mk(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                                input logic [1:0] rs2, input logic sel, input logic [7:0] imm);
    instr_t i;
    i.op = op; i.rd = rd; i.rs1 = rs1; i.rs2 = rs2; i.sel = sel; i.imm = imm;
    return i;
  endfunction

  function automatic instr_t rand_instr();
    int s;
    s = $urandom_range(0, 3);
    return mk((s < 2) ? OP_ADD : ((s == 2) ? OP_LOADI : 4'($urandom_range(0, 14))),
              2'($urandom), 2'($urandom), 2'($urandom), 1'($urandom), 8'($urandom));
  endfunction

  task automatic drive(input instr_t i);
    bus.instr_valid = 1'b1;
    bus.instr_op    = i.op;
    bus.instr_rd    = i.rd;
    bus.instr_rs1   = i.rs1;
    bus.instr_rs2   = i.rs2;
    bus.imm_sel     = i.sel;
    bus.instr_imm   = i.imm;
  endtask

  task automatic idle_bus();
    bus.instr_valid = 1'b0;
    bus.instr_op    = 4'($urandom);
    bus.instr_rd    = 2'($urandom);
    bus.instr_rs1   = 2'($urandom);
    bus.instr_rs2   = 2'($urandom);
    bus.imm_sel     = 1'($urandom);
    bus.instr_imm   = 8'($urandom);
  endtask

  task automatic model_reset();
    for (int i = 0; i < int'(NREG); i++) rf_m[i] = 8'h00;
    flags_m   = 4'h0;
    perf_i_m  = 0;
    perf_cf_m = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_alu"}, 32'({bus.alu_en, bus.alu_oe, bus.alu_opcode, bus.alu_a, bus.alu_b}), 32'h0);
    chk({tag, "_done"}, 32'({bus.done_valid, bus.done_rd, bus.done_data}), 32'h0);
    chk({tag, "_status"}, 32'({busy, bus.instr_ready, flags}), 32'h0);
  endtask

  // Called at a negedge with the instruction on the bus; returns just after the accepting edge.
  task automatic wait_accept(output int waited);
    waited = 0;
    while (!bus.instr_ready && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.instr_ready) chk("accept_timeout", 32'(bus.instr_ready), 32'h1);
    @(posedge clk);
  endtask

  // Follows one accepted instruction cycle by cycle and ends at the negedge of the next IDLE cycle.
  task automatic observe(input instr_t i, input logic [7:0] a, input logic [7:0] b);
    bit          loadi;
    int          exp_done;
    int          en_n, oe_n, done_n, done_k, en_k, bad_busy, bad_hold;
    logic [11:0] r;
    logic [7:0]  exp_data;
    loadi    = (i.op == OP_LOADI);
    exp_done = loadi ? 1 : int'(ALU_LAT) + 2;
    r        = alu_fn(i.op, a, b);
    exp_data = loadi ? i.imm : r[7:0];
    en_n = 0; oe_n = 0; done_n = 0; done_k = 0; en_k = 0; bad_busy = 0; bad_hold = 0;
    dbg_addr = i.rd;
    for (int k = 1; k <= exp_done + 1; k++) begin
      @(negedge clk);
      if (bus.alu_en) begin
        en_n++;
        if (en_k == 0) en_k = k;
      end
      if (bus.alu_oe) oe_n++;
      if (bus.done_valid) begin
        done_n++;
        if (done_k == 0) begin
          done_k = k;
          chk("done_rd", 32'(bus.done_rd), 32'(i.rd));
          chk("done_data", 32'(bus.done_data), 32'(exp_data));
        end
      end
      if (k <= exp_done && (busy !== 1'b1 || bus.instr_ready !== 1'b0)) bad_busy++;
      if (!loadi && k < exp_done &&
          (bus.alu_opcode !== i.op || bus.alu_a !== a || bus.alu_b !== b)) bad_hold++;
      if (k == exp_done) chk("rf_before_wb", 32'(dbg_data), 32'(rf_m[i.rd]));
    end
    chk("idle_busy_ready", 32'({busy, bus.instr_ready}), 32'h1);
    chk("alu_en_cycles", 32'(en_n), loadi ? 32'h0 : 32'h1);
    if (!loadi) chk("alu_en_position", 32'(en_k), 32'h1);
    chk("alu_oe_cycles", 32'(oe_n), loadi ? 32'h0 : 32'(ALU_LAT));
    chk("done_latency", 32'(done_k), 32'(exp_done));
    chk("done_pulses", 32'(done_n), 32'h1);
    chk("busy_window", 32'(bad_busy), 32'h0);
    if (!loadi) chk("operands", 32'(bad_hold), 32'h0);
    rf_m[i.rd] = exp_data;
    if (!loadi) flags_m = r[11:8];
    chk("rf_after_wb", 32'(dbg_data), 32'(exp_data));
    chk("flags", 32'(flags), 32'(flags_m));
`ifdef ALU_SEQ_PERF_EN
    perf_i_m++;
    if (!loadi && r[11]) perf_cf_m++;
    chk("perf_instr_cnt", 32'(perf_instr_cnt), 32'(perf_i_m[15:0]));
    chk("perf_cf_cnt", 32'(perf_cf_cnt), 32'(perf_cf_m[15:0]));
`endif
  endtask

  task automatic run_queue();
    step_t      cur, nxt;
    int         waited;
    bit         have_next;
    logic [7:0] a, b;
    if (q.size() == 0) return;
    cur = q.pop_front();
    drive(cur.ins);
    while (1) begin
      wait_accept(waited);
      if (cur.mode == 2) chk("held_accept_wait", 32'(waited), 32'h0);
      a = rf_m[cur.ins.rs1];
      b = cur.ins.sel ? cur.ins.imm : rf_m[cur.ins.rs2];
      have_next = (q.size() != 0);
      if (have_next) nxt = q.pop_front();
      #1;
      if (have_next && nxt.mode == 2) drive(nxt.ins);
      else idle_bus();
      observe(cur.ins, a, b);
      if (!have_next) break;
      if (nxt.mode == 0) repeat ($urandom_range(0, 2)) @(negedge clk);
      if (nxt.mode != 2) drive(nxt.ins);
      cur = nxt;
    end
  endtask

  task automatic reset_mid_wait();
    int waited;
    int seen_done;
    drive(mk(OP_ADD, 2'd3, 2'd0, 2'd1, 1'b0, 8'h00));
    wait_accept(waited);
    #1 idle_bus();
    @(negedge clk);
    @(negedge clk);
    chk("pre_reset_in_wait", 32'({bus.alu_oe, busy}), 32'h3);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    seen_done = 0;
    repeat (ALU_LAT + 3) begin
      @(negedge clk);
      if (bus.done_valid) seen_done++;
    end
    chk("no_done_after_abort", 32'(seen_done), 32'h0);
    for (int i = 0; i < int'(NREG); i++) begin
      dbg_addr = 2'(i);
      #1 chk("rf_cleared", 32'(dbg_data), 32'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("ready_after_release", 32'(bus.instr_ready), 32'h1);
    model_reset();
`ifdef ALU_SEQ_PERF_EN
    chk("perf_cleared", 32'({perf_instr_cnt, perf_cf_cnt}), 32'h0);
`endif
    @(negedge clk);
  endtask

  task automatic push_random(input int n);
    for (int k = 0; k < n; k++) q.push_back('{ins: rand_instr(), mode: $urandom_range(0, 2)});
  endtask

  initial begin
    rst_n    = 1'b0;
    dbg_addr = 2'd0;
    idle_bus();
    model_reset();
    #3;
    check_reset_outputs("por");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1 chk("ready_after_por", 32'(bus.instr_ready), 32'h1);

    q.push_back('{ins: mk(OP_LOADI, 2'd1, 2'd0, 2'd0, 1'b0, 8'h7F), mode: 0});
    q.push_back('{ins: mk(OP_LOADI, 2'd1, 2'd0, 2'd0, 1'b0, 8'hF0), mode: 0});
    q.push_back('{ins: mk(OP_ADD,   2'd2, 2'd1, 2'd0, 1'b1, 8'h20), mode: 0});
    q.push_back('{ins: mk(OP_ADD,   2'd2, 2'd2, 2'd2, 1'b0, 8'h00), mode: 1});
    q.push_back('{ins: mk(OP_ADD,   2'd0, 2'd2, 2'd1, 1'b0, 8'h00), mode: 0});
    q.push_back('{ins: mk(OP_LOADI, 2'd3, 2'd0, 2'd0, 1'b0, 8'hAA), mode: 2});
    q.push_back('{ins: mk(4'h5,     2'd3, 2'd3, 2'd0, 1'b0, 8'h00), mode: 2});
    run_queue();
    chk("plan_rf2_raw", 32'(rf_m[2]), 32'h20);

    push_random(60);
    run_queue();

    reset_mid_wait();

    push_random(15);
    run_queue();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
